// File: rtl/rrarb_idx.sv
// Round-robin arbiter that returns the winner as a registered binary index.
// Define RRARB_LOCK_EN to add the gnt_lock input for locked (burst) grants.
module rrarb_idx #(
  parameter int NREQ   = 48,
  parameter int IDXWID = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic              gnt_ack,
  output logic              gnt_vld,
  output logic [IDXWID-1:0] gnt_idx
`ifdef RRARB_LOCK_EN
  ,
  input  logic              gnt_lock
`endif
);

  localparam logic [0:0] STATE_IDLE  = 1'b0;
  localparam logic [0:0] STATE_GRANT = 1'b1;

  localparam int                PADW     = 2 ** IDXWID;
  localparam logic [IDXWID:0]   NREQ_W   = (IDXWID + 1)'(NREQ);
  localparam logic [IDXWID-1:0] LAST_IDX = IDXWID'(NREQ - 1);

  logic [0:0]        state;
  logic [IDXWID-1:0] ptr;
  logic [IDXWID-1:0] nxt_ptr;
  logic [IDXWID-1:0] srch_ptr;
  logic [PADW-1:0]   req_pad;
  logic [PADW-1:0]   srch_req;
  logic [IDXWID:0]   cand;
  logic [IDXWID-1:0] win_idx;
  logic              win_vld;
  logic              do_release;

  // Padding req to the full index range keeps every index select in bounds.
  assign req_pad  = PADW'(req);
  assign nxt_ptr  = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDXWID'(1);
  assign srch_ptr = (state == STATE_GRANT) ? nxt_ptr : ptr;
  assign srch_req = (state == STATE_GRANT) ? (req_pad & ~(PADW'(1) << gnt_idx))
                                           : req_pad;
  assign gnt_vld  = (state == STATE_GRANT);

`ifdef RRARB_LOCK_EN
  assign do_release = gnt_ack & ~gnt_lock;
`else
  assign do_release = gnt_ack;
`endif

  // Scan downward in offset so the smallest offset from srch_ptr wins last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, srch_ptr} + (IDXWID + 1)'(k);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (srch_req[cand[IDXWID-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[IDXWID-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= STATE_IDLE;
      gnt_idx <= '0;
      ptr     <= '0;
    end else if (state == STATE_IDLE) begin
      if (win_vld) begin
        state   <= STATE_GRANT;
        gnt_idx <= win_idx;
      end
    end else if (do_release) begin
      ptr <= nxt_ptr;
      if (win_vld) begin
        gnt_idx <= win_idx;
      end else begin
        state <= STATE_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_rrarb_idx.sv
// Directed scoreboard bench for rrarb_idx: expectations are queued as each
// step is driven and popped once the DUT output settles after the edge.
module tb_rrarb_idx;

  logic        clk;
  logic        rst;
  logic [47:0] req;
  logic        gnt_ack;
  logic        gnt_vld;
  logic [5:0]  gnt_idx;
`ifdef RRARB_LOCK_EN
  logic        gnt_lock;
`endif

  typedef struct {
    string      tag;
    logic       vld;
    logic [5:0] idx;
    bit         chkidx;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  rrarb_idx #(.NREQ(48), .IDXWID(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt_ack (gnt_ack),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
`ifdef RRARB_LOCK_EN
    ,
    .gnt_lock(gnt_lock)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pushExp(input string tag, input logic ev, input logic [5:0] ei,
                         input bit ci);
    exp_t e;
    e.tag    = tag;
    e.vld    = ev;
    e.idx    = ei;
    e.chkidx = ci;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      $error("[TB] FAIL scoreboard: no expectation queued, got vld=%0b idx=%0d",
             gnt_vld, gnt_idx);
    end else begin
      e = sb.pop_front();
      checks++;
      assert (gnt_vld === e.vld) passes++;
      else $error("[TB] FAIL %s: gnt_vld got %0b expected %0b", e.tag, gnt_vld, e.vld);
      if (e.chkidx) begin
        checks++;
        assert (gnt_idx === e.idx) passes++;
        else $error("[TB] FAIL %s: gnt_idx got %0d expected %0d", e.tag, gnt_idx, e.idx);
      end
    end
  endtask

  task automatic applyStimulus(input logic [47:0] r, input logic a, input string tag,
                               input logic ev, input logic [5:0] ei, input bit ci);
    req     = r;
    gnt_ack = a;
    pushExp(tag, ev, ei, ci);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Pulse reset between edges with the inputs idle and check it acts at once.
  task automatic asyncReset(input string tag);
    #3;
    rst     = 1'b1;
    req     = '0;
    gnt_ack = 1'b0;
    #1;
    pushExp(tag, 1'b0, 6'd0, 1'b1);
    checkOutput();
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b0;
    req     = '0;
    gnt_ack = 1'b0;
`ifdef RRARB_LOCK_EN
    gnt_lock = 1'b0;
`endif
    #2;
    rst = 1'b1;
    #1;
    pushExp("reset", 1'b0, 6'd0, 1'b1);
    checkOutput();
    @(posedge clk);
    #1;
    rst = 1'b0;

    applyStimulus(48'h5, 1'b0, "first_grant", 1'b1, 6'd0, 1'b1);
    for (int i = 0; i < 10; i++)
      applyStimulus(48'h5, 1'b0, "grant_hold", 1'b1, 6'd0, 1'b1);

    applyStimulus(48'h5, 1'b1, "b2b_0", 1'b1, 6'd2, 1'b1);
    applyStimulus(48'h5, 1'b1, "b2b_1", 1'b1, 6'd0, 1'b1);
    applyStimulus(48'h5, 1'b1, "b2b_2", 1'b1, 6'd2, 1'b1);
    applyStimulus(48'h5, 1'b1, "b2b_3", 1'b1, 6'd0, 1'b1);

    asyncReset("async_rst_in_grant");
    applyStimulus(48'h0, 1'b1, "idle_ack_0", 1'b0, 6'd0, 1'b0);
    applyStimulus(48'h0, 1'b1, "idle_ack_1", 1'b0, 6'd0, 1'b0);
    applyStimulus(48'h9, 1'b0, "ptr_after_rst", 1'b1, 6'd0, 1'b1);

    applyStimulus(48'h9, 1'b1, "rr_to_3", 1'b1, 6'd3, 1'b1);
    applyStimulus(48'h24, 1'b1, "rr_to_5", 1'b1, 6'd5, 1'b1);
    applyStimulus(48'h14, 1'b0, "hold_drop_0", 1'b1, 6'd5, 1'b1);
    applyStimulus(48'h14, 1'b0, "hold_drop_1", 1'b1, 6'd5, 1'b1);
    applyStimulus(48'h14, 1'b1, "wrap_after_5", 1'b1, 6'd2, 1'b1);
    applyStimulus((48'h1 << 40) | 48'h4, 1'b1, "up_to_40", 1'b1, 6'd40, 1'b1);
    applyStimulus(48'h0, 1'b1, "release_idle", 1'b0, 6'd0, 1'b0);

    applyStimulus(48'h1 << 47, 1'b1, "top_grant_0", 1'b1, 6'd47, 1'b1);
    applyStimulus(48'h1 << 47, 1'b1, "top_idle_0", 1'b0, 6'd0, 1'b0);
    applyStimulus(48'h1 << 47, 1'b1, "top_grant_1", 1'b1, 6'd47, 1'b1);
    applyStimulus(48'h1 << 47, 1'b1, "top_idle_1", 1'b0, 6'd0, 1'b0);
    applyStimulus((48'h1 << 47) | 48'h2, 1'b0, "ptr_wrapped", 1'b1, 6'd1, 1'b1);

`ifdef RRARB_LOCK_EN
    asyncReset("lock_reset");
    applyStimulus(48'h8, 1'b0, "lock_first", 1'b1, 6'd3, 1'b1);
    gnt_lock = 1'b1;
    for (int i = 0; i < 3; i++)
      applyStimulus(48'h18, 1'b1, "lock_hold", 1'b1, 6'd3, 1'b1);
    gnt_lock = 1'b0;
    applyStimulus(48'h18, 1'b1, "lock_release", 1'b1, 6'd4, 1'b1);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rrarb_idx.md
RRARB_IDX -- requirements
Module: rrarb_idx

Interface
REQ-001 Parameter NREQ, default 48: number of requesters; SHALL be between 2 and 2^IDXWID inclusive.
REQ-002 Parameter IDXWID, default 6: width of the encoded grant index; it matches the input width of the downstream decodex stage.
REQ-003 Port clk  input  1: single clock; all state is updated on its rising edge.
REQ-004 Port rst  input  1: reset, asynchronous and active-high.
REQ-005 Port req  input  NREQ: per-requester request level, where bit i requests for index i.
REQ-006 Port gnt_ack  input  1: consumer accepts the current grant.
REQ-007 Port gnt_vld  output  1: a grant is held.
REQ-008 Port gnt_idx  output  IDXWID: binary index of the granted requester, registered.
REQ-009 Port gnt_lock  input  1: exists only when RRARB_LOCK_EN is defined (see Configuration).

Function
REQ-010 The state machine SHALL have two states: IDLE (gnt_vld=0) and GRANT (gnt_vld=1).
REQ-011 The search SHALL pick the first set req bit at or after pointer ptr (IDXWID bits), scanning upward and wrapping from NREQ-1 to 0.
REQ-012 In IDLE with any req bit set at edge N, the block SHALL enter GRANT at edge N, so gnt_vld=1 and gnt_idx=winner in cycle N+1 (latency 1).
REQ-013 In GRANT, gnt_idx and gnt_vld SHALL hold stable until gnt_ack=1 is sampled, even if req[gnt_idx] deasserts.
REQ-014 On an ack edge, ptr SHALL become gnt_idx+1, wrapping to 0 when gnt_idx=NREQ-1.
REQ-015 On an ack edge, the search SHALL run from the new ptr over the current req with the bit of the just-acked index masked.
  - If a winner exists, it SHALL be loaded immediately, giving back-to-back grants with gnt_vld staying 1.
  - Otherwise the block SHALL return to IDLE.
REQ-016 A lone requester SHALL therefore get at most one grant per two cycles; alternate requesters SHALL get one grant per cycle.
REQ-017 gnt_ack sampled while in IDLE SHALL be ignored, with no change to state or ptr.
REQ-018 req bits at index NREQ or above do not exist; gnt_idx SHALL never exceed NREQ-1.
REQ-019 ptr SHALL change only on an ack edge, never in IDLE.

Reset
REQ-020 Asserting rst SHALL immediately, without waiting for a clock edge, force state=IDLE, gnt_vld=0, gnt_idx=0 and ptr=0.
REQ-021 Reset asserted in GRANT SHALL discard the held grant; no ack is required.
REQ-022 The first edge after rst deasserts SHALL arbitrate normally from ptr=0.

Configuration
REQ-023 Macro RRARB_LOCK_EN, when defined, SHALL add input gnt_lock and the following behaviour:
  - An ack edge with gnt_lock=1 SHALL keep state, gnt_idx and ptr unchanged, so the same requester retains the grant for a burst.
  - An ack with gnt_lock=0 SHALL behave as in REQ-014 and REQ-015.
REQ-024 When RRARB_LOCK_EN is not defined, the gnt_lock port and its logic SHALL be absent, and every ack SHALL release per REQ-014 and REQ-015.

Verification
REQ-025 Reset then req=0x000000000005, no ack -> cycle 1: gnt_vld=1, gnt_idx=0; the grant holds for 10 cycles unchanged.
REQ-026 req=0x000000000005 with ack held high -> gnt_idx sequence 0,2,0,2 on consecutive cycles with no gnt_vld gap.
REQ-027 Only req[47] set, ack each cycle -> gnt_idx=47, then IDLE for one cycle, then 47 again; ptr wraps to 0 after each ack.
REQ-028 Granted idx 5, deassert req[5] before ack -> gnt_idx remains 5 until ack; then the next winner is the lowest set index at or above 6, wrapping.
REQ-029 rst pulsed asynchronously mid-GRANT between clock edges -> gnt_vld=0 and gnt_idx=0 before the next edge; ack pulses in IDLE leave ptr=0.
REQ-030 With RRARB_LOCK_EN defined: idx 3 granted, three acks with gnt_lock=1 then an ack with gnt_lock=0 and req=0x18 -> gnt_idx 3,3,3,3, then 4.
